// File: rtl/rs_encode_wrapper.sv
// Systematic RS(255,223) encoder over GF(2^8) for a byte stream: forwards the
// 223 message bytes, then emits the 32 parity bytes from the division LFSR.
module rs_encode_wrapper (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       src_encoder_start_encode,
  input  logic       src_encoder_data_enable,
  input  logic [7:0] src_encoder_data,
  output logic       encoder_src_encoding,
  output logic       encoder_dst_data_val,
  output logic [7:0] encoder_dst_data
);

  // state    | meaning
  // S_IDLE   | waiting for a start pulse
  // S_DATA   | accepting and forwarding message bytes, LFSR dividing
  // S_PARITY | shifting parity out, r[31] first

  localparam int         K         = 223;
  localparam int         NPAR      = 32;
  localparam logic [8:0] PRIM_POLY = 9'h11D;
  localparam int         FCR       = 0;

  localparam logic [7:0] LAST_IDX = 8'(K - 1);
  localparam logic [4:0] LAST_PAR = 5'(NPAR - 1);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ PRIM_POLY[7:0]) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // Coefficients g_0..g_31 of the monic generator prod (x + alpha^(FCR+i)).
  function automatic logic [NPAR-1:0][7:0] gen_poly();
    logic [NPAR:0][7:0] g;
    logic [7:0]         root;
    g    = '0;
    g[0] = 8'h01;
    root = 8'h01;
    for (int i = 0; i < FCR; i++) root = gf_mul(root, 8'h02);
    for (int i = 0; i < NPAR; i++) begin
      for (int j = NPAR; j > 0; j--) g[j] = g[j-1] ^ gf_mul(g[j], root);
      g[0] = gf_mul(g[0], root);
      root = gf_mul(root, 8'h02);
    end
    return g[NPAR-1:0];
  endfunction

  localparam logic [NPAR-1:0][7:0] G_COEF = gen_poly();

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [1:0]           r_rst_sync;
  logic [NPAR-1:0][7:0] r_par;
  logic [NPAR-1:0][7:0] w_par_feed;
  logic [7:0]           w_fb;
  logic [7:0]           r_cnt;
  logic [4:0]           r_pcnt;
  logic                 r_dval;
  logic [7:0]           r_data;
  logic                 w_start_ok;
  logic                 w_accept;
  logic                 w_last_byte;
  logic                 w_shift;
  logic                 w_last_par;

  // Reset asserts asynchronously but is released two clocks later, in sync with clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_state <= S_IDLE;
    else if (!r_rst_sync[1]) r_state <= S_IDLE;
    else                     r_state <= w_state_nxt;
  end

  // The final parity byte is still on the output in the first IDLE cycle, so a
  // start there is refused; busy covers that cycle too.
  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = (r_state == S_IDLE) && src_encoder_start_encode && !r_dval;
    w_accept    = (r_state == S_DATA) && src_encoder_data_enable;
    w_last_byte = w_accept && (r_cnt == LAST_IDX);
    w_shift     = (r_state == S_PARITY);
    w_last_par  = w_shift && (r_pcnt == LAST_PAR);
    case (r_state)
      S_IDLE:   if (w_start_ok)  w_state_nxt = S_DATA;
      S_DATA:   if (w_last_byte) w_state_nxt = S_PARITY;
      S_PARITY: if (w_last_par)  w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_par_feed    = '0;
    w_fb          = src_encoder_data ^ r_par[NPAR-1];
    w_par_feed[0] = gf_mul(w_fb, G_COEF[0]);
    for (int i = 1; i < NPAR; i++) w_par_feed[i] = r_par[i-1] ^ gf_mul(w_fb, G_COEF[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par  <= '0;
      r_cnt  <= '0;
      r_pcnt <= '0;
      r_dval <= 1'b0;
      r_data <= '0;
    end else if (!r_rst_sync[1]) begin
      r_par  <= '0;
      r_cnt  <= '0;
      r_pcnt <= '0;
      r_dval <= 1'b0;
      r_data <= '0;
    end else begin
      if (w_start_ok) begin
        r_par  <= '0;
        r_cnt  <= '0;
        r_pcnt <= '0;
      end else if (w_accept) begin
        r_par <= w_par_feed;
        if (!w_last_byte) r_cnt <= r_cnt + 8'd1;
      end else if (w_shift) begin
        r_par  <= {r_par[NPAR-2:0], 8'h00};
        r_pcnt <= r_pcnt + 5'd1;
      end
      r_dval <= w_accept || w_shift;
      if (w_accept)     r_data <= src_encoder_data;
      else if (w_shift) r_data <= r_par[NPAR-1];
      else              r_data <= '0;
    end
  end

  assign encoder_src_encoding = (r_state != S_IDLE) || r_dval;
  assign encoder_dst_data_val = r_dval;
  assign encoder_dst_data     = r_data;

endmodule

// File: tb/tb_rs_encode_wrapper.sv
// Scoreboard bench for rs_encode_wrapper: expected bytes are queued as stimulus
// is driven, parity comes from polynomial long division, syndromes re-check it.
module tb_rs_encode_wrapper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       en = 1'b0;
  logic [7:0] din = 8'h00;
  logic       enc;
  logic       val;
  logic [7:0] dout;

  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         acc_q[$];
  logic [7:0] got[255];
  logic [7:0] msg[223];
  logic [7:0] exp_par[32];
  logic [7:0] gpoly[33];

  rs_encode_wrapper dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .src_encoder_start_encode (start),
    .src_encoder_data_enable  (en),
    .src_encoder_data         (din),
    .encoder_src_encoding     (enc),
    .encoder_dst_data_val     (val),
    .encoder_dst_data         (dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
    end
    return p;
  endfunction

  task automatic build_gpoly();
    logic [7:0] root;
    for (int j = 0; j < 33; j++) gpoly[j] = 8'h00;
    gpoly[0] = 8'h01;
    root = 8'h01;
    for (int i = 0; i < 32; i++) begin
      for (int j = 32; j > 0; j--) gpoly[j] = gpoly[j-1] ^ gf_mul(gpoly[j], root);
      gpoly[0] = gf_mul(gpoly[0], root);
      root = gf_mul(root, 8'h02);
    end
  endtask

  // Remainder of m(x)*x^32 divided by g(x); exp_par[0] is the x^31 coefficient.
  task automatic model_parity();
    logic [7:0] b[255];
    logic [7:0] c;
    for (int k = 0; k < 255; k++) b[k] = (k < 223) ? msg[k] : 8'h00;
    for (int k = 0; k < 223; k++) begin
      c = b[k];
      if (c != 8'h00)
        for (int j = 1; j <= 32; j++) b[k+j] = b[k+j] ^ gf_mul(c, gpoly[32-j]);
    end
    for (int i = 0; i < 32; i++) exp_par[i] = b[223+i];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int gap_mode, input int viol_mode);
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (enc !== 1'b1) begin
      failures++;
      $display("FAIL enc_rise: encoding=%b expected 1 after start edge", enc);
    end
    for (int k = 0; k < 223; k++) begin
      if (gap_mode != 0 && $urandom_range(0, 3) == 0) begin
        en = 1'b0;
        din = 8'($urandom);
        repeat ($urandom_range(1, 5)) begin
          if (viol_mode != 0) start = 1'b1;
          step();
          start = 1'b0;
        end
      end
      if (viol_mode != 0 && (k % 50) == 7) start = 1'b1;
      en = 1'b1;
      din = msg[k];
      exp_q.push_back(msg[k]);
      step();
      acc_q.push_back(cyc);
      start = 1'b0;
    end
    en = 1'b0;
    din = 8'h00;
    model_parity();
    for (int i = 0; i < 32; i++) exp_q.push_back(exp_par[i]);
    if (viol_mode != 0) begin
      for (int i = 0; i < 10; i++) begin
        en = 1'b1;
        din = 8'($urandom);
        start = (i % 3 == 0);
        step();
      end
      en = 1'b0;
      start = 1'b0;
      din = 8'h00;
    end
  endtask

  task automatic monitor(input int contig);
    int         n;
    int         budget;
    int         last_acc;
    int         prev;
    int         a;
    logic [7:0] e;
    n = 0;
    budget = 0;
    last_acc = 0;
    prev = 0;
    while (n < 255 && budget < 3000) begin
      @(negedge clk);
      budget++;
      if (val === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_empty: byte %0d value %h with nothing expected", n, dout);
        end else begin
          e = exp_q.pop_front();
          if (dout !== e) begin
            failures++;
            $display("FAIL byte_%0d: got %h expected %h", n, dout, e);
          end
        end
        got[n] = dout;
        checks++;
        if (n < 223) begin
          a = (acc_q.size() > 0) ? acc_q.pop_front() : -100;
          last_acc = a;
          if (cyc !== a) begin
            failures++;
            $display("FAIL latency_%0d: seen in cycle %0d expected %0d", n, cyc, a);
          end
        end else if (cyc !== last_acc + 1 + (n - 223)) begin
          failures++;
          $display("FAIL parity_timing_%0d: seen in cycle %0d expected %0d", n - 223, cyc, last_acc + 1 + (n - 223));
        end
        if (contig != 0 && n > 0) begin
          checks++;
          if (cyc !== prev + 1) begin
            failures++;
            $display("FAIL contiguous_%0d: cycle %0d expected %0d", n, cyc, prev + 1);
          end
        end
        prev = cyc;
        n++;
      end else begin
        checks++;
        if (dout !== 8'h00) begin
          failures++;
          $display("FAIL data_when_invalid: got %h expected 00", dout);
        end
      end
    end
    checks++;
    if (n < 255) begin
      failures++;
      $display("FAIL timeout: only %0d of 255 bytes seen, expected 255", n);
    end else begin
      if (enc !== 1'b1) begin
        failures++;
        $display("FAIL enc_last_byte: encoding=%b expected 1", enc);
      end
      @(negedge clk);
      checks++;
      if (enc !== 1'b0 || val !== 1'b0 || dout !== 8'h00) begin
        failures++;
        $display("FAIL enc_fall: enc=%b val=%b data=%h expected 0 0 00", enc, val, dout);
      end
    end
  endtask

  task automatic run_encode(input int gap_mode, input int viol_mode, input int contig);
    exp_q.delete();
    acc_q.delete();
    fork
      drive(gap_mode, viol_mode);
      monitor(contig);
    join
  endtask

  task automatic check_syndromes(input string tag);
    logic [7:0] root;
    logic [7:0] s;
    root = 8'h01;
    for (int i = 0; i < 32; i++) begin
      s = 8'h00;
      for (int k = 0; k < 255; k++) s = gf_mul(s, root) ^ got[k];
      checks++;
      if (s !== 8'h00) begin
        failures++;
        $display("FAIL %s_syndrome_%0d: got %h expected 00", tag, i, s);
      end
      root = gf_mul(root, 8'h02);
    end
  endtask

  task automatic set_incrementing();
    for (int k = 0; k < 223; k++) msg[k] = 8'(k + 1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      start = 1'b1;
      en = 1'b1;
      din = 8'hA5;
      @(negedge clk);
      checks++;
      if (enc !== 1'b0 || val !== 1'b0 || dout !== 8'h00) begin
        failures++;
        $display("FAIL reset_outputs: enc=%b val=%b data=%h expected 0 0 00", enc, val, dout);
      end
    end
    start = 1'b0;
    en = 1'b0;
    din = 8'h00;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (enc !== 1'b0 || val !== 1'b0 || dout !== 8'h00) begin
        failures++;
        $display("FAIL reset_release: enc=%b val=%b data=%h expected 0 0 00", enc, val, dout);
      end
    end
  endtask

  task automatic test_idle_enable();
    for (int i = 0; i < 6; i++) begin
      en = 1'b1;
      din = 8'($urandom);
      @(negedge clk);
      checks++;
      if (enc !== 1'b0 || val !== 1'b0 || dout !== 8'h00) begin
        failures++;
        $display("FAIL idle_enable: enc=%b val=%b data=%h expected 0 0 00", enc, val, dout);
      end
    end
    en = 1'b0;
    din = 8'h00;
  endtask

  task automatic test_incrementing();
    set_incrementing();
    run_encode(0, 0, 1);
    check_syndromes("incr");
  endtask

  task automatic test_all_zero();
    for (int k = 0; k < 223; k++) msg[k] = 8'h00;
    run_encode(0, 0, 1);
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (got[223+i] !== 8'h00) begin
        failures++;
        $display("FAIL zero_parity_%0d: got %h expected 00", i, got[223+i]);
      end
    end
  endtask

  task automatic test_gapped();
    set_incrementing();
    run_encode(1, 0, 0);
    check_syndromes("gap");
  endtask

  task automatic test_violations();
    for (int k = 0; k < 223; k++) msg[k] = 8'($urandom);
    run_encode(1, 1, 0);
    check_syndromes("viol");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 223; k++) msg[k] = 8'(255 - k);
    run_encode(0, 0, 1);
    set_incrementing();
    run_encode(0, 0, 1);
    check_syndromes("b2b");
  endtask

  task automatic test_reset_mid();
    set_incrementing();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      en = 1'b1;
      din = msg[k];
      step();
    end
    en = 1'b0;
    din = 8'h00;
    rst_n = 1'b0;
    #1;
    checks++;
    if (enc !== 1'b0 || val !== 1'b0 || dout !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_immediate: enc=%b val=%b data=%h expected 0 0 00", enc, val, dout);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (enc !== 1'b0 || val !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_idle: enc=%b val=%b expected 0 0", enc, val);
      end
    end
    run_encode(0, 0, 1);
    check_syndromes("after_rst");
  endtask

  initial begin
    build_gpoly();
    test_reset();
    test_idle_enable();
    test_incrementing();
    test_all_zero();
    test_gapped();
    test_violations();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rs_encode_wrapper.md
# rs_encode_wrapper

Systematic Reed-Solomon RS(255,223) encoder over GF(2^8), wrapped for a byte-streaming datapath. It accepts one 223-byte message per encode operation and emits a 255-byte codeword: the 223 message bytes unchanged, then 32 parity bytes. The block sits between a byte source and a byte sink, and drives a busy flag back to the source.

## Interface
Parameters (fixed constants, not overridable):
- `K`, 223, message symbols per codeword
- `NPAR`, 32, parity symbols per codeword
- `PRIM_POLY`, 9'h11D, field polynomial x^8+x^4+x^3+x^2+1; alpha = 8'h02
- `FCR`, 0, generator g(x) = prod_{i=0..31} (x + alpha^i)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `src_encoder_start_encode`  in  1  one-cycle pulse that starts an encode operation
- `src_encoder_data_enable`  in  1  qualifies `src_encoder_data`
- `src_encoder_data`  in  8  message byte
- `encoder_src_encoding`  out  1  busy; high while an operation is in progress
- `encoder_dst_data_val`  out  1  output byte valid
- `encoder_dst_data`  out  8  codeword byte

## Operation
- States:
  - IDLE: waits for a start pulse.
  - DATA: accepts message bytes.
  - PARITY: emits parity bytes.
  - Return to IDLE afterwards.
- IDLE:
  - Start sampled high → clear all 32 parity registers and the byte counter; go to DATA.
  - `data_enable` is ignored in IDLE.
- DATA:
  - Each cycle with `data_enable` high accepts one byte.
  - Gaps (enable low) are allowed; they stall the counter and the LFSR.
  - LFSR update per accepted byte d:
    - fb = d ^ r[31]
    - r[i] = r[i-1] ^ gmul(fb, g_i) for i = 31..1
    - r[0] = gmul(fb, g_0)
  - g_i are the constant coefficients of monic g(x). gmul is GF(2^8) multiplication modulo `PRIM_POLY`, implemented as constant multipliers.
  - Each accepted byte is forwarded to the output unchanged.
  - After the 223rd accepted byte, go to PARITY.
- PARITY:
  - Outputs r[31] first, down to r[0], one per cycle, with no gaps, while shifting with zero feedback.
  - After the 32nd parity byte, go to IDLE.
- Start pulses outside IDLE are ignored. `data_enable` in PARITY is ignored.
- Byte counter: 8 bits, counts 0..222; there is no wrap within an operation.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, LFSR and counter cleared, all outputs 0.
- Reset mid-operation aborts immediately. No partial codeword is completed afterwards.
- Start sampled at edge S → `encoding` is high from S until the edge that ends the last parity cycle.
- Message byte accepted at edge E → `dst_data_val` = 1 and `dst_data` = byte during the cycle after E (1-cycle latency).
- Last (223rd) byte accepted at edge L:
  - Cycle L+1 shows message byte 223.
  - Parity bytes 0..31 appear in cycles L+2 .. L+33 with `dst_data_val` high.
  - `encoding` falls at edge L+33.
- With back-to-back input starting the cycle after start, the 255 output bytes are contiguous.
- `dst_data_val` is 0 whenever no byte is being output. `dst_data` is 0 when not valid.
- A new start is accepted in the first cycle after `encoding` falls.

## Test plan
- **Reset:** hold `rst_n` low for 10 cycles → all outputs 0. Pulse start and enable during reset → no response.
- **Incrementing message:**
  - Stimulus: start pulse, then bytes 1..223 back-to-back.
  - Required output: bytes 1..223 with 1-cycle latency, then 32 contiguous parity bytes matching a software RS(255,223) model (0x11D, FCR 0).
  - `encoding` spans exactly start through the last parity byte.
  - All 32 syndromes of the 255-byte output evaluate to 0.
- **All-zero message:** 223 bytes of 0x00 → 32 parity bytes all 0x00.
- **Gapped input:** same message as the incrementing test, with `data_enable` dropped for random 1–5 cycle gaps → identical parity; output message bytes appear 1 cycle after each accepted byte.
- **Protocol violations:**
  - Extra start pulses during DATA and PARITY are ignored; output stays correct.
  - `data_enable` high in IDLE or PARITY does not affect the LFSR or the output.
- **Reset mid-message:** assert `rst_n` low after 100 bytes → outputs go to 0 immediately. A following full encode of 1..223 produces correct parity.
